// File: rtl/netlist_pkg.sv
// Shared definitions for the netlist evaluator: sizes, gate entry layout, opcodes, FSM states.
// Entry layout (MSB..LSB): op, fanin_cnt, out_net, in0, in1, in2, in3.
package netlist_pkg;

   localparam int N_GATES    = 16;
   localparam int N_NETS     = 32;
   localparam int N_PI       = 8;
   localparam int MAX_FANIN  = 4;
   localparam int MAX_PASSES = 8;

   localparam int GW      = $clog2(N_GATES);
   localparam int NW      = $clog2(N_NETS);
   localparam int PW      = $clog2(MAX_PASSES) + 1;
   localparam int OPW     = 3;
   localparam int CW      = 3;
   localparam int ENTRY_W = OPW + CW + NW + MAX_FANIN * NW;

   localparam int IN3_LSB = 0;
   localparam int IN2_LSB = IN3_LSB + NW;
   localparam int IN1_LSB = IN2_LSB + NW;
   localparam int IN0_LSB = IN1_LSB + NW;
   localparam int OUT_LSB = IN0_LSB + NW;
   localparam int CNT_LSB = OUT_LSB + NW;
   localparam int OP_LSB  = CNT_LSB + CW;

   localparam logic [OPW-1:0] OP_BUF  = 3'd0;
   localparam logic [OPW-1:0] OP_NOT  = 3'd1;
   localparam logic [OPW-1:0] OP_AND  = 3'd2;
   localparam logic [OPW-1:0] OP_OR   = 3'd3;
   localparam logic [OPW-1:0] OP_NAND = 3'd4;
   localparam logic [OPW-1:0] OP_NOR  = 3'd5;
   localparam logic [OPW-1:0] OP_XOR  = 3'd6;
   localparam logic [OPW-1:0] OP_XNOR = 3'd7;

   // in_net[0] sits at the MSB end so the struct overlays the packed entry exactly.
   typedef struct packed {
      logic [OPW-1:0]                  op;
      logic [CW-1:0]                   fanin_cnt;
      logic [NW-1:0]                   out_net;
      logic [0:MAX_FANIN-1][NW-1:0]    in_net;
   } gate_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_PI,
      ST_EVAL,
      ST_CHECK,
      ST_FIN
   } state_t;

endpackage

// File: rtl/gate_eval_alu.sv
// Combinational single-gate evaluator: zero latency, no flow control.
// Fan-in of 0 acts as 1, fan-in above MAX_FANIN is clamped; BUF/NOT look at in0 only.
module gate_eval_alu
   import netlist_pkg::*;
(
   input  logic [OPW-1:0]       op,
   input  logic [CW-1:0]        fanin_cnt,
   input  logic [MAX_FANIN-1:0] in_bits,
   output logic                 result
);

   logic [CW-1:0]        eff_cnt;
   logic [MAX_FANIN-1:0] mask;
   logic                 and_r;
   logic                 or_r;
   logic                 xor_r;

   always_comb begin
      eff_cnt = fanin_cnt;
      if (fanin_cnt == '0)
         eff_cnt = CW'(1);
      else if (fanin_cnt > CW'(MAX_FANIN))
         eff_cnt = CW'(MAX_FANIN);
      mask = '0;
      for (int i = 0; i < MAX_FANIN; i++)
         mask[i] = (i < int'(eff_cnt));
   end

   // Unused inputs are forced to the identity value of each reduction.
   assign and_r = &(in_bits | ~mask);
   assign or_r  = |(in_bits & mask);
   assign xor_r = ^(in_bits & mask);

   always_comb begin
      result = 1'b0;
      unique case (op)
         OP_BUF:  result = in_bits[0];
         OP_NOT:  result = ~in_bits[0];
         OP_AND:  result = and_r;
         OP_OR:   result = or_r;
         OP_NAND: result = ~and_r;
         OP_NOR:  result = ~or_r;
         OP_XOR:  result = xor_r;
         OP_XNOR: result = ~xor_r;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/netlist_eval_sched.sv
// Gate-table sequencer: evaluates one gate per cycle, repeating passes until settled or the pass limit.
// Latency start->done is 2+P*(G+1) cycles; start and cfg_we are ignored while busy.
module netlist_eval_sched
   import netlist_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [GW-1:0]      cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_data,
   input  logic [GW:0]        cfg_num_gates,
   input  logic [N_PI-1:0]    pi_val,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               settle_err,
   output logic [PW-1:0]      passes,
   input  logic [NW-1:0]      rd_addr,
   output logic               rd_data
);

   state_t               state;
   state_t               state_nxt;
   gate_entry_t          gate_tbl [N_GATES];
   gate_entry_t          cur;
   logic [N_NETS-1:0]    nets;
   logic [GW:0]          num_gates;
   logic [GW-1:0]        gate_idx;
   logic                 changed;
   logic [N_PI-1:0]      pi_lat;
   logic [PW-1:0]        pass_cnt;
   logic [PW-1:0]        pass_inc;
   logic                 err_q;
   logic [MAX_FANIN-1:0] in_bits;
   logic                 alu_res;
   logic                 wr_ok;
   logic                 differs;
   logic                 last_gate;
   logic                 pass_limit;

   assign cur = gate_tbl[gate_idx];

   always_comb begin
      in_bits = '0;
      for (int i = 0; i < MAX_FANIN; i++)
         in_bits[i] = nets[cur.in_net[i]];
   end

   gate_eval_alu u_alu (
      .op        (cur.op),
      .fanin_cnt (cur.fanin_cnt),
      .in_bits   (in_bits),
      .result    (alu_res)
   );

   // Primary-input nets are owned by pi_val; gate writes to them are dropped.
   assign wr_ok      = (cur.out_net >= NW'(N_PI));
   assign differs    = (alu_res != nets[cur.out_net]);
   assign last_gate  = ({1'b0, gate_idx} == (num_gates - 1'b1));
   assign pass_inc   = pass_cnt + 1'b1;
   assign pass_limit = (pass_inc == PW'(MAX_PASSES));

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = ST_LOAD_PI;
         end
         ST_LOAD_PI:
            state_nxt = (num_gates == '0) ? ST_FIN : ST_EVAL;
         ST_EVAL:
            if (last_gate)
               state_nxt = ST_CHECK;
         ST_CHECK:
            state_nxt = (!changed || pass_limit) ? ST_FIN : ST_EVAL;
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // Table holds no reset so the loader's contents survive a sequencer reset.
   always_ff @(posedge clk) begin
      if (cfg_we && state == ST_IDLE)
         gate_tbl[cfg_addr] <= cfg_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nets      <= '0;
         num_gates <= '0;
         gate_idx  <= '0;
         changed   <= 1'b0;
         pi_lat    <= '0;
         pass_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (start) begin
                  pass_cnt  <= '0;
                  err_q     <= 1'b0;
                  pi_lat    <= pi_val;
                  num_gates <= (cfg_num_gates > (GW+1)'(N_GATES)) ? (GW+1)'(N_GATES)
                                                                   : cfg_num_gates;
               end
            ST_LOAD_PI: begin
               nets[N_PI-1:0] <= pi_lat;
               gate_idx       <= '0;
               changed        <= 1'b0;
            end
            ST_EVAL: begin
               if (wr_ok) begin
                  nets[cur.out_net] <= alu_res;
                  if (differs)
                     changed <= 1'b1;
               end
               gate_idx <= gate_idx + 1'b1;
            end
            ST_CHECK: begin
               pass_cnt <= pass_inc;
               if (changed && pass_limit)
                  err_q <= 1'b1;
               gate_idx <= '0;
               changed  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign settle_err = err_q;
   assign passes     = pass_cnt;
   assign rd_data    = nets[rd_addr];

endmodule

// File: doc/netlist_eval_sched.md
Name: netlist_eval_sched

Overview:
- Sequencer for the gate-level netlist evaluator.
- Holds a programmable gate table and a net-value register file.
- On start, evaluates gates one per cycle in table order, repeating full passes until no net changes or a pass limit is hit.
- Sits between the netlist loader (config writes) and the simulation host (start/done, net readback).

Parameters:
- N_GATES, 16, gate table depth.
- N_NETS, 32, net register file size (indices 0..N_NETS-1).
- N_PI, 8, primary-input nets (indices 0..N_PI-1).
- MAX_FANIN, 4, inputs per gate entry.
- MAX_PASSES, 8, pass limit before settle error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  gate table write strobe.
- cfg_addr  in  clog2(N_GATES)  gate entry index.
- cfg_data  in  ENTRY_W  packed entry: {op[2:0], fanin_cnt[2:0], out_net[NW-1:0], in0..in3[NW-1:0]}.
- cfg_num_gates  in  clog2(N_GATES)+1  active gate count, sampled at start.
- pi_val  in  N_PI  primary input values, sampled at start.
- start  in  1  begin evaluation (single-cycle pulse).
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle completion pulse.
- settle_err  out  1  pass limit reached without settling; held until next start.
- passes  out  clog2(MAX_PASSES)+1  passes executed; held until next start.
- rd_addr  in  NW  net readback index.
- rd_data  out  1  net value, combinational from rd_addr.

Behaviour:
- Reset: busy=0, done=0, settle_err=0, passes=0, all net values 0, state IDLE. Gate table contents are not reset.
- Opcodes: 0 BUF, 1 NOT, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR (parity), 7 XNOR.
- Only inputs in0..in(fanin_cnt-1) are used. fanin_cnt of 0 is treated as 1; values above MAX_FANIN are clamped to MAX_FANIN. BUF and NOT use in0 only.
- States: IDLE, LOAD_PI, EVAL, CHECK, FIN.
  - IDLE: start → LOAD_PI, busy=1, clear settle_err/passes, latch cfg_num_gates.
  - LOAD_PI (1 cycle): nets 0..N_PI-1 ← pi_val. If num_gates==0 → FIN with passes=0. Otherwise gate_idx=0, changed=0 → EVAL.
  - EVAL (1 cycle per gate): compute the result combinationally from current net values, write out_net at the clock edge, set changed if the value differs.
    - Later gates in the same pass see earlier writes.
    - gate_idx==num_gates-1 → CHECK.
  - CHECK (1 cycle): passes+1.
    - changed==0 → FIN.
    - Else if passes+1==MAX_PASSES → FIN with settle_err=1.
    - Else gate_idx=0, changed=0 → EVAL.
  - FIN (1 cycle): done=1, busy=0 next cycle → IDLE.
- Latency: start at cycle T; done asserted at T+2+P*(G+1), where G is the gate count and P the passes executed.
- Multiple drivers of one net: last writer in table order wins within each pass.
- Writes targeting nets 0..N_PI-1 are suppressed and do not set changed.
- start while busy: ignored.
- cfg_we while busy: ignored; table is stable during evaluation.
- Net values persist after FIN. The next start reloads PIs but keeps internal nets as the initial state.
- rst mid-operation: immediate return to reset values next cycle, no done pulse.

Decomposition:
- Shared package netlist_pkg: opcode localparams (OP_BUF..OP_XNOR), ENTRY_W/NW derivation, entry field offsets, state encoding.
- Sub-module gate_eval_alu: combinational; op, fanin_cnt, 4 input bits → result.

Test Plan:
1. Gate0 {NOT, cnt1, out8, in0}, num_gates=1, pi_val=0, start → pass1 sets net8=1, pass2 no change; done at start+6, passes=2, settle_err=0, rd_data(8)=1.
2. Gate0 {NOT, out8, in8} (self-loop oscillator) → done, settle_err=1, passes=8, busy low after done.
3. Reverse-ordered chain: g0 {BUF, out10, in9}, g1 {BUF, out9, in8}, g2 {NOT, out8, in0}, pi_val=0 → passes=4, nets 8/9/10 all 1.
4. Gate0 {XOR, cnt4, out8, in0..in3}, pi_val=8'b0000_1011 → net8=1. Then pi_val=8'b0000_0011, restart → net8=0.
5. Multi-driver: g0 {AND, out8, in0,in1}, g1 {NAND, out8, in0,in1}, pi_val=8'b11 → net8=0. Write to net 3 is suppressed; start while busy is ignored.
6. Assert rst during EVAL of a 16-gate table → next cycle busy=0, passes=0, all rd_data=0, no done pulse; start afterward completes normally.
